// File: rtl/traffic_pkg.sv
// traffic_pkg: definitions shared by the signal-head decoder and its BCD
// converter.
//   - Phase codes OFF/LEFT/FORWARD/RIGHT as carried on the phase bus.
//   - state_t: decoder FSM states (SYNC, TRACK, FAULT).
//   - next_phase(): the one legal successor of a phase. The cycle is
//     OFF -> FORWARD -> RIGHT -> LEFT -> OFF.
//   - dd_step(): one double-dabble iteration on a {tens, ones, bin} register.
//   - BCD_MAX: the largest value the two-digit display can show.
package traffic_pkg;

    localparam logic [1:0] OFF     = 2'd0;
    localparam logic [1:0] LEFT    = 2'd1;
    localparam logic [1:0] FORWARD = 2'd2;
    localparam logic [1:0] RIGHT   = 2'd3;

    localparam int BCD_MAX = 99;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    function automatic logic [1:0] next_phase(input logic [1:0] phase);
        logic [1:0] nxt;
        case (phase)
            OFF:     nxt = FORWARD;
            FORWARD: nxt = RIGHT;
            RIGHT:   nxt = LEFT;
            LEFT:    nxt = OFF;
            default: nxt = OFF;
        endcase
        return nxt;
    endfunction

    // Register layout: [14:11] tens, [10:7] ones, [6:0] binary still to shift.
    // Any digit of 5 or more gets +3 before the shift, so it carries correctly.
    function automatic logic [14:0] dd_step(input logic [14:0] sr);
        logic [14:0] adj;
        adj        = sr;
        adj[14:11] = (sr[14:11] >= 4'd5) ? (sr[14:11] + 4'd3) : sr[14:11];
        adj[10:7]  = (sr[10:7]  >= 4'd5) ? (sr[10:7]  + 4'd3) : sr[10:7];
        return adj << 1;
    endfunction

endpackage

// File: rtl/signal_head_decoder_if.sv
// signal_head_decoder_if: traffic-phase bus from the phase sequencer to the
// signal-head decoder.
//   phase_in : 2-bit phase code (OFF/LEFT/FORWARD/RIGHT)
//   count_in : remaining seconds of the current phase
// Modports: master = sequencer (drives), slave = decoder (receives).
interface signal_head_decoder_if #(
    parameter int CNT_W = 32
);
    logic [1:0]       phase_in;
    logic [CNT_W-1:0] count_in;

    modport master (output phase_in, output count_in);
    modport slave  (input  phase_in, input  count_in);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter from a 7-bit value to two
// BCD digits.
// Timing: start is accepted on an idle edge, which loads the value. The next
// seven edges each perform one shift iteration. The seventh shift also latches
// tens/ones and pulses done, so done arrives on the 8th edge after start.
//   clk, reset : clock, asynchronous active-high reset
//   flush      : synchronous abort; drops any conversion, clears the digits
//   start      : begin a conversion of bin (ignored while busy)
//   bin        : value to convert (0..99)
//   busy       : a conversion is in progress
//   done       : one-cycle pulse when tens/ones take a new value
//   tens, ones : latched BCD result
module bin2bcd_seq
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [14:0] sr_r;
    logic [2:0]  cnt_r;
    logic        busy_r;
    logic        done_r;
    logic [3:0]  tens_r;
    logic [3:0]  ones_r;
    logic [14:0] step_s;

    assign step_s = dd_step(sr_r);

    // Load, shift seven times, and latch the result together with the last shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_r   <= 15'd0;
            cnt_r  <= 3'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            tens_r <= 4'd0;
            ones_r <= 4'd0;
        end else if (flush) begin
            sr_r   <= 15'd0;
            cnt_r  <= 3'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            tens_r <= 4'd0;
            ones_r <= 4'd0;
        end else begin
            done_r <= 1'b0;
            if (busy_r) begin
                sr_r  <= step_s;
                cnt_r <= cnt_r + 3'd1;
                if (cnt_r == 3'd6) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    tens_r <= step_s[14:11];
                    ones_r <= step_s[10:7];
                end
            end else if (start) begin
                sr_r   <= {8'd0, bin};
                cnt_r  <= 3'd0;
                busy_r <= 1'b1;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign tens = tens_r;
    assign ones = ones_r;

endmodule

// File: rtl/signal_head_decoder.sv
// signal_head_decoder: the receive end of the traffic-phase bus. It drives the
// signal-head lamps and a 2-digit BCD countdown display. It also checks that
// phases arrive in the legal order; after an illegal step, the head flashes
// amber until the sequencer sends the OFF/0 override signature.
// Optional feature, enabled by the macro SEQ_DWELL_CHECK_EN: in TRACK, the
// count must fall by exactly one per cycle while the phase is held. On a phase
// change, the previous count must have been at or below 1.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   bus (slave)                : phase_in / count_in from the sequencer
//   lamp_red, lamp_amber       : all-stop red, amber
//   arrow_left/fwd/right       : green arrows
//   bcd_tens, bcd_ones         : countdown digits
//   disp_valid                 : one-cycle pulse when the digits update
//   seq_err                    : high while in FAULT
module signal_head_decoder
    import traffic_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int WARN_SECS  = 3,
    parameter int FLASH_HALF = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    signal_head_decoder_if.slave  bus,
    output logic                  lamp_red,
    output logic                  lamp_amber,
    output logic                  arrow_left,
    output logic                  arrow_fwd,
    output logic                  arrow_right,
    output logic [3:0]            bcd_tens,
    output logic [3:0]            bcd_ones,
    output logic                  disp_valid,
    output logic                  seq_err
);

    localparam int              FC_W    = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLASH_HALF - 1);

    logic [1:0]       phase_q;
    logic [1:0]       prev_phase_q;
    logic [CNT_W-1:0] count_q;
`ifdef SEQ_DWELL_CHECK_EN
    logic [CNT_W-1:0] prev_count_q;
`endif

    logic [FC_W-1:0] flash_cnt_r;
    logic            blink_r;

    state_t     state_r;
    logic       red_r;
    logic       amber_r;
    logic [2:0] arrows_r;   // {left, fwd, right}
    logic       seq_err_r;

    logic [6:0] last_r;
    logic       pend_r;

    logic       sync_hit_s;
    logic       order_bad_s;
    logic       dwell_bad_s;
    logic       fault_entry_s;
    logic       override_s;
    logic       warn_s;
    logic [2:0] dec_arrows_s;
    logic [2:0] track_arrows_s;
    logic [6:0] sat_s;
    logic       conv_en_s;
    logic       flush_s;
    logic       start_s;
    logic       busy_s;

    // Input stage, plus a one-cycle history used for the order checks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= OFF;
            prev_phase_q <= OFF;
            count_q      <= '0;
`ifdef SEQ_DWELL_CHECK_EN
            prev_count_q <= '0;
`endif
        end else begin
            phase_q      <= bus.phase_in;
            prev_phase_q <= phase_q;
            count_q      <= bus.count_in;
`ifdef SEQ_DWELL_CHECK_EN
            prev_count_q <= count_q;
`endif
        end
    end

    // Free-running blink generator. Phase changes never restart it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flash_cnt_r <= '0;
            blink_r     <= 1'b0;
        end else if (flash_cnt_r == FC_LAST) begin
            flash_cnt_r <= '0;
            blink_r     <= ~blink_r;
        end else begin
            flash_cnt_r <= flash_cnt_r + FC_W'(1);
        end
    end

    // Legality checks, lamp decode and converter control for the current cycle.
    always_comb begin
        sync_hit_s  = (prev_phase_q == OFF) && (phase_q == FORWARD);
        order_bad_s = (phase_q != prev_phase_q) && (phase_q != next_phase(prev_phase_q));
        dwell_bad_s = 1'b0;
`ifdef SEQ_DWELL_CHECK_EN
        if (phase_q == prev_phase_q) begin
            dwell_bad_s = (count_q != (prev_count_q - CNT_W'(1)));
        end else begin
            // A reload is only acceptable once the old phase has run out.
            dwell_bad_s = (prev_count_q > CNT_W'(1));
        end
`endif
        fault_entry_s = (state_r == TRACK) && (order_bad_s || dwell_bad_s);
        override_s    = (phase_q == OFF) && (count_q == '0);
        warn_s        = (phase_q != OFF) && (count_q <= CNT_W'(WARN_SECS));

        case (phase_q)
            LEFT:    dec_arrows_s = 3'b100;
            FORWARD: dec_arrows_s = 3'b010;
            RIGHT:   dec_arrows_s = 3'b001;
            default: dec_arrows_s = 3'b000;
        endcase
        track_arrows_s = warn_s ? (dec_arrows_s & {3{blink_r}}) : dec_arrows_s;

        sat_s = (count_q > CNT_W'(BCD_MAX)) ? 7'(BCD_MAX) : count_q[6:0];

        // The display runs only in TRACK, including the cycle that enters TRACK.
        // A FAULT entry on the same edge blanks the display and overrides a completion.
        conv_en_s = ((state_r == TRACK) && !fault_entry_s) ||
                    ((state_r == SYNC) && sync_hit_s);
        flush_s   = !conv_en_s;
        start_s   = conv_en_s && !busy_s && (pend_r || (sat_s != last_r));
    end

    // Sequence FSM with registered lamp outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= SYNC;
            red_r     <= 1'b1;
            amber_r   <= 1'b0;
            arrows_r  <= 3'b000;
            seq_err_r <= 1'b0;
        end else begin
            case (state_r)
                SYNC: begin
                    seq_err_r <= 1'b0;
                    if (sync_hit_s) begin
                        state_r  <= TRACK;
                        red_r    <= 1'b0;
                        amber_r  <= warn_s;
                        arrows_r <= track_arrows_s;
                    end else begin
                        red_r    <= 1'b1;
                        amber_r  <= 1'b0;
                        arrows_r <= 3'b000;
                    end
                end
                TRACK: begin
                    if (fault_entry_s) begin
                        state_r   <= FAULT;
                        seq_err_r <= 1'b1;
                        red_r     <= 1'b0;
                        amber_r   <= blink_r;
                        arrows_r  <= 3'b000;
                    end else begin
                        seq_err_r <= 1'b0;
                        red_r     <= (phase_q == OFF);
                        amber_r   <= warn_s;
                        arrows_r  <= track_arrows_s;
                    end
                end
                FAULT: begin
                    if (override_s) begin
                        state_r   <= SYNC;
                        seq_err_r <= 1'b0;
                        red_r     <= 1'b1;
                        amber_r   <= 1'b0;
                        arrows_r  <= 3'b000;
                    end else begin
                        seq_err_r <= 1'b1;
                        red_r     <= 1'b0;
                        amber_r   <= blink_r;
                        arrows_r  <= 3'b000;
                    end
                end
                default: begin
                    state_r   <= SYNC;
                    seq_err_r <= 1'b0;
                    red_r     <= 1'b1;
                    amber_r   <= 1'b0;
                    arrows_r  <= 3'b000;
                end
            endcase
        end
    end

    // Remember the last started value and hold at most one pending restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r <= 7'd0;
            pend_r <= 1'b0;
        end else if (flush_s) begin
            // The display is blanked to 0/0, so 0 is what it now shows.
            last_r <= 7'd0;
            pend_r <= 1'b0;
        end else if (start_s) begin
            last_r <= sat_s;
            pend_r <= 1'b0;
        end else if (busy_s && (sat_s != last_r)) begin
            pend_r <= 1'b1;
        end
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .flush (flush_s),
        .start (start_s),
        .bin   (sat_s),
        .busy  (busy_s),
        .done  (disp_valid),
        .tens  (bcd_tens),
        .ones  (bcd_ones)
    );

    assign lamp_red    = red_r;
    assign lamp_amber  = amber_r;
    assign arrow_left  = arrows_r[2];
    assign arrow_fwd   = arrows_r[1];
    assign arrow_right = arrows_r[0];
    assign seq_err     = seq_err_r;

endmodule

// File: tb/tb_signal_head_decoder.sv
// Directed testbench for signal_head_decoder. Two scoreboard queues hold the
// expected values. The lamp queue is popped two cycles after each drive. The
// display queue is popped on each disp_valid pulse, and each entry carries the
// edge number at which its pulse is due.
module tb_signal_head_decoder;
    import traffic_pkg::*;

    localparam int CNT_W      = 32;
    localparam int WARN_SECS  = 3;
    localparam int FLASH_HALF = 1;

    typedef struct packed {
        logic        red;
        logic [1:0]  amb;     // 0/1 literal, 2 = blink
        logic [2:0]  arr;     // {left, fwd, right}
        logic        arr_bl;  // arrows gated by blink
        logic        err;
    } lamp_exp_t;

    typedef struct packed {
        logic [3:0]  tens;
        logic [3:0]  ones;
        logic [31:0] due;
    } bcd_exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       lamp_red, lamp_amber, arrow_left, arrow_fwd, arrow_right;
    logic [3:0] bcd_tens, bcd_ones;
    logic       disp_valid, seq_err;

    signal_head_decoder_if #(.CNT_W(CNT_W)) bus ();

    signal_head_decoder #(
        .CNT_W      (CNT_W),
        .WARN_SECS  (WARN_SECS),
        .FLASH_HALF (FLASH_HALF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .lamp_red    (lamp_red),
        .lamp_amber  (lamp_amber),
        .arrow_left  (arrow_left),
        .arrow_fwd   (arrow_fwd),
        .arrow_right (arrow_right),
        .bcd_tens    (bcd_tens),
        .bcd_ones    (bcd_ones),
        .disp_valid  (disp_valid),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release; used to place blink and display timing.
    int edge_n;
    always @(posedge clk or posedge reset) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    lamp_exp_t lq[$];
    bcd_exp_t  bq[$];
    int        checks;
    int        errors;
    bit        bcd_chk;

    function automatic lamp_exp_t mk_lamp(input logic red, input logic [1:0] amb,
                                          input logic [2:0] arr, input logic arr_bl,
                                          input logic err);
        lamp_exp_t e;
        e.red = red; e.amb = amb; e.arr = arr; e.arr_bl = arr_bl; e.err = err;
        return e;
    endfunction

    function automatic lamp_exp_t red_e();
        return mk_lamp(1'b1, 2'd0, 3'b000, 1'b0, 1'b0);
    endfunction

    function automatic lamp_exp_t flt_e();
        return mk_lamp(1'b0, 2'd2, 3'b000, 1'b0, 1'b1);
    endfunction

    function automatic lamp_exp_t arw(input logic [2:0] a, input int cnt);
        if (cnt <= WARN_SECS) return mk_lamp(1'b0, 2'd1, a, 1'b1, 1'b0);
        else                  return mk_lamp(1'b0, 2'd0, a, 1'b0, 1'b0);
    endfunction

    function automatic bcd_exp_t mk_bcd(input logic [3:0] t, input logic [3:0] o, input int due);
        bcd_exp_t b;
        b.tens = t; b.ones = o; b.due = 32'(due);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_lamps"}, 32'({lamp_red, lamp_amber, arrow_left, arrow_fwd, arrow_right}), 32'(5'b10000));
        chk({tag, "_digits"}, 32'({bcd_tens, bcd_ones}), 32'd0);
        chk({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
        chk({tag, "_seq_err"}, 32'(seq_err), 32'd0);
    endtask

    // Drive one cycle, then score the lamps due now and any display pulse.
    task automatic step(input logic [1:0] ph, input int cnt, input lamp_exp_t e);
        lamp_exp_t  x;
        bcd_exp_t   b;
        logic       bl;
        logic       amb;
        logic [2:0] arr;
        bus.phase_in = ph;
        bus.count_in = 32'(cnt);
        lq.push_back(e);
        @(posedge clk);
        #1;
        // Blink level registered into the lamps on edge n: ((n-1)/FLASH_HALF) mod 2.
        bl = ((((edge_n - 1) / FLASH_HALF) % 2) == 1);
        if (lq.size() == 2) begin
            x   = lq.pop_front();
            amb = (x.amb == 2'd2) ? bl : x.amb[0];
            arr = x.arr_bl ? (x.arr & {3{bl}}) : x.arr;
            chk("lamps", 32'({lamp_red, lamp_amber, arrow_left, arrow_fwd, arrow_right}),
                32'({x.red, amb, arr}));
            chk("seq_err", 32'(seq_err), 32'(x.err));
        end
        if (bcd_chk && (disp_valid === 1'b1)) begin
            if (bq.size() == 0) begin
                chk("spurious_disp_valid", 32'(disp_valid), 32'd0);
            end else begin
                b = bq.pop_front();
                chk("bcd_digits", 32'({bcd_tens, bcd_ones}), 32'({b.tens, b.ones}));
                chk("bcd_latency", 32'(edge_n), b.due);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        bcd_chk = 1'b0;
        reset   = 1'b1;
        bus.phase_in = OFF;
        bus.count_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        #2 reset = 1'b0;

        // Normal sequence: SYNC until OFF->FORWARD, then the full legal cycle.
        for (int c = 3; c >= 1; c--)  step(OFF, c, red_e());
        for (int c = 15; c >= 1; c--) step(FORWARD, c, arw(3'b010, c));
        for (int c = 10; c >= 1; c--) step(RIGHT, c, arw(3'b001, c));
        for (int c = 10; c >= 1; c--) step(LEFT, c, arw(3'b100, c));
        for (int c = 3; c >= 1; c--)  step(OFF, c, red_e());
        repeat (24) step(OFF, 0, red_e());
        chk("settled_digits", 32'({bcd_tens, bcd_ones}), 32'd0);

        // Single conversions: 15 -> 1/5, then 250 saturates to 9/9.
        bcd_chk = 1'b1;
        bq.push_back(mk_bcd(4'd1, 4'd5, edge_n + 9));
        repeat (12) step(FORWARD, 15, arw(3'b010, 15));
        bq.push_back(mk_bcd(4'd9, 4'd9, edge_n + 9));
        repeat (12) step(FORWARD, 250, arw(3'b010, 250));
        chk("bcd_single_all_seen", 32'(bq.size()), 32'd0);

        // Back-to-back changes: 15 converts, and 13 follows as the single pending value.
        bq.push_back(mk_bcd(4'd1, 4'd5, edge_n + 9));
        bq.push_back(mk_bcd(4'd1, 4'd3, edge_n + 17));
        step(FORWARD, 15, arw(3'b010, 15));
        step(FORWARD, 14, arw(3'b010, 14));
        repeat (19) step(FORWARD, 13, arw(3'b010, 13));
        chk("pending_all_seen", 32'(bq.size()), 32'd0);
        chk("pending_final_digits", 32'({bcd_tens, bcd_ones}), 32'({4'd1, 4'd3}));

        // Illegal FORWARD -> LEFT: flashing amber fault, display blanked.
        repeat (5) step(LEFT, 10, flt_e());
        chk("fault_digits", 32'({bcd_tens, bcd_ones}), 32'd0);
        repeat (6) step(OFF, 0, red_e());

        // Count skip 15 -> 13 while FORWARD is held.
`ifdef SEQ_DWELL_CHECK_EN
        step(FORWARD, 15, arw(3'b010, 15));
        repeat (20) step(FORWARD, 13, flt_e());
`else
        bq.push_back(mk_bcd(4'd1, 4'd5, edge_n + 9));
        bq.push_back(mk_bcd(4'd1, 4'd3, edge_n + 17));
        step(FORWARD, 15, arw(3'b010, 15));
        repeat (20) step(FORWARD, 13, arw(3'b010, 13));
`endif
        chk("dwell_bcd_all_seen", 32'(bq.size()), 32'd0);

        // Asynchronous reset in the middle of a conversion at RIGHT/5.
        repeat (3) step(RIGHT, 5, arw(3'b001, 5));
        #3 reset = 1'b1;
        #1;
        check_reset_values("midconv");
        lq.delete();
        bus.phase_in = OFF;
        bus.count_in = '0;
        @(posedge clk);
        #3 reset = 1'b0;
        repeat (12) step(OFF, 0, red_e());
        chk("post_reset_digits", 32'({bcd_tens, bcd_ones}), 32'd0);
        chk("final_bcd_queue", 32'(bq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/signal_head_decoder.md
Name: signal_head_decoder

Overview:
- Receive end of the traffic-phase interface: consumes the 2-bit phase code and countdown value produced by the phase sequencer.
- Drives the physical signal-head lamps and a 2-digit BCD countdown display.
- Checks phase-order legality; on a violation, forces the head into flashing-amber fault mode.
- Sits between the sequencer and the lamp/display pad drivers.

Parameters:
- CNT_W, 32, width of count_in.
- WARN_SECS, 3, countdown value at or below which an active arrow blinks and amber is lit.
- FLASH_HALF, 1, clk cycles per half-period of the blink waveform. The blink toggles every FLASH_HALF cycles.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- phase_in  in  2  phase code: 0=OFF, 1=LEFT, 2=FORWARD, 3=RIGHT
- count_in  in  CNT_W  remaining seconds of the current phase
- lamp_red  out  1  all-stop red
- lamp_amber  out  1  amber
- arrow_left  out  1  left green arrow
- arrow_fwd  out  1  forward green arrow
- arrow_right  out  1  right green arrow
- bcd_tens  out  4  display tens digit
- bcd_ones  out  4  display ones digit
- disp_valid  out  1  one-cycle pulse when the BCD digits update
- seq_err  out  1  sticky; high while in FAULT

Behaviour:
- Clock/reset: reset is asynchronous, active-high; clock is clk, and all state changes on its rising edge.
- Reset values:
  - lamp_red=1; every other lamp output 0.
  - bcd_tens=0, bcd_ones=0, disp_valid=0, seq_err=0.
  - FSM in SYNC; flash counter 0, blink phase 0.
- Input stage: phase_in and count_in are registered (phase_q, count_q). Lamp outputs are registered from phase_q/count_q, giving 2 cycles from input to lamp.
- Legal order: OFF -> FORWARD -> RIGHT -> LEFT -> OFF. Holding the same phase is always legal.
- FSM states SYNC, TRACK, FAULT:
  - SYNC:
    - Lamps: red only.
    - Go to TRACK on the first cycle where prev phase_q=OFF and phase_q=FORWARD; lamps decode that cycle.
    - Any other transition is ignored.
  - TRACK:
    - Lamp decode:
      - OFF: red=1.
      - FORWARD: arrow_fwd.
      - RIGHT: arrow_right.
      - LEFT: arrow_left.
      - Red is 0 in every non-OFF phase.
    - Warning: if phase_q != OFF and count_q <= WARN_SECS, amber=1 and the active arrow = blink.
    - Any phase change that is not the legal successor -> FAULT.
  - FAULT:
    - seq_err=1; red=0, all arrows=0, amber=blink.
    - Return to SYNC when phase_q=OFF and count_q=0 (sequencer manual override/reset signature). seq_err clears on that same edge.
- Blink: free-running counter toggles the blink phase every FLASH_HALF cycles. It runs in all states and is never restarted by phase changes.
- BCD display:
  - count_q is saturated to 99 and converted by a sequential double-dabble converter: 7 shift iterations, result latched on the 8th cycle after start, with disp_valid pulsed on that cycle.
  - A conversion starts when the saturated value differs from the last converted value and the converter is idle.
  - A change during a busy conversion sets a pending flag. The converter completes the current conversion, then starts again with the newest value; at most one pending conversion is held.
  - In SYNC and FAULT the display is held at 0/0, with no disp_valid.
- Reset mid-conversion: the conversion is abandoned and the digits return to 0.
- Simultaneous events: a FAULT entry and a BCD completion on the same edge → FAULT wins; the digits are forced to 0 and disp_valid=0.

Optional Feature:
- Macro: SEQ_DWELL_CHECK_EN.
- Defined: in TRACK, when phase_q is unchanged, count_q must equal prev count_q - 1. Exception: while prev count_q <= 1, count_q may equal a reload value on a phase change only. Any other count change -> FAULT.
- Undefined: count values are not checked; only phase order is checked.

Decomposition:
- Shared package (traffic_pkg):
  - Phase code constants OFF/LEFT/FORWARD/RIGHT.
  - FSM state typedef.
  - Function next_phase(phase) returning the legal successor.
  - Constant BCD_MAX=99.
- One sub-module: bin2bcd_seq (7-bit in, start/busy/done, two BCD digits out). Lamp decode and the FSM stay in the top module.

Test Plan:
- Normal sequence: reset, then OFF/3 -> FORWARD/15 -> RIGHT/10 -> LEFT/10 -> OFF/3, decrementing each cycle → red only in SYNC; TRACK entered at FORWARD; arrow_fwd lit; amber and blinking arrow at count 3,2,1; seq_err stays 0 throughout.
- BCD: FORWARD with count 15 → disp_valid pulse 8 cycles after count_q update with tens=1, ones=5. Count 250 → tens=9, ones=9.
- Illegal order: in TRACK, drive FORWARD -> LEFT → seq_err=1, all arrows 0, red 0, amber toggling each FLASH_HALF cycle. Then OFF/0 → SYNC, seq_err=0, red=1.
- Pending conversion: change count 15 -> 14 -> 13 on consecutive cycles → exactly two disp_valid pulses, final digits 1/3.
- Async reset asserted mid-conversion while in TRACK at RIGHT/5 → all outputs immediately at reset values, no disp_valid after release.
- With SEQ_DWELL_CHECK_EN defined: FORWARD counts 15 -> 13 → FAULT. Without the macro, the same stimulus stays in TRACK.
